ay_stereo_mixer: RTL

Downstream stage of the AY/TurboSound sound path. Takes the three 8-bit log-DAC channel outputs of up to two AY-3-8912 instances, which update on the shared `clken`. Sequentially mixes them into a 16-bit unsigned left/right sample pair using a selectable stereo panning mode, then presents the pair to the audio output path (I2S/sigma-delta feeder) over a valid/ready handshake.

---
 rtl/ay_pkg.sv | 17 +
 rtl/ay_mix_coef.sv | 44 ++++
 rtl/ay_stereo_mixer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ay_pkg.sv
// rtl/ay_pkg.sv - shared constants and types for the AY stereo mixer
package ay_pkg;

  localparam logic [1:0] AY_MIX_ABC  = 2'b00;
  localparam logic [1:0] AY_MIX_ACB  = 2'b01;
  localparam logic [1:0] AY_MIX_MONO = 2'b10;

  typedef enum logic [1:0] {
    AY_ST_IDLE = 2'd0,
    AY_ST_ACC  = 2'd1,
    AY_ST_HOLD = 2'd2
  } ay_state_t;

  localparam int AY_STEPS     = 6;
  localparam int AY_OUT_SHIFT = 5;

endpackage

// File: rtl/ay_mix_coef.sv
// rtl/ay_mix_coef.sv - panning weights per (mode, step); the only place panning lives
module ay_mix_coef
  import ay_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [2:0] step,
  output logic [1:0] w_l,
  output logic [1:0] w_r
);

  logic [2:0] ch;

  always_comb begin
    ch  = (step >= 3'd3) ? 3'(step - 3'd3) : step;
    w_l = 2'd0;
    w_r = 2'd0;
    // ch 0/1/2 = A/B/C of whichever AY; steps past the last source weigh nothing
    case (mode)
      AY_MIX_MONO: begin
        if (ch < 3'd3) begin
          w_l = 2'd1;
          w_r = 2'd1;
        end
      end
      AY_MIX_ACB: begin
        case (ch)
          3'd0:    w_l = 2'd2;
          3'd1:    w_r = 2'd2;
          3'd2:    begin w_l = 2'd1; w_r = 2'd1; end
          default: ;
        endcase
      end
      default: begin
        case (ch)
          3'd0:    w_l = 2'd2;
          3'd1:    begin w_l = 2'd1; w_r = 2'd1; end
          3'd2:    w_r = 2'd2;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ay_stereo_mixer.sv
// rtl/ay_stereo_mixer.sv - sequential six-source stereo mixer with valid/ready output
module ay_stereo_mixer
  import ay_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic [1:0]       mode,
  input  logic             ts_en,
  input  logic [CH_W-1:0]  ay0_a,
  input  logic [CH_W-1:0]  ay0_b,
  input  logic [CH_W-1:0]  ay0_c,
  input  logic [CH_W-1:0]  ay1_a,
  input  logic [CH_W-1:0]  ay1_b,
  input  logic [CH_W-1:0]  ay1_c,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovr,
  input  logic             ovr_clr
);

  localparam int ACC_W = CH_W + 3;
  localparam logic [2:0] LAST_STEP = 3'(AY_STEPS);

  ay_state_t         state;
  logic [2:0]        step;
  logic [1:0]        mode_q;
  logic              ts_q;
  logic [CH_W-1:0]   snap [6];
  logic [ACC_W-1:0]  acc_l;
  logic [ACC_W-1:0]  acc_r;

  logic [1:0]        w_l;
  logic [1:0]        w_r;
  logic [CH_W-1:0]   src;
  logic [ACC_W-1:0]  term_l;
  logic [ACC_W-1:0]  term_r;
  logic [OUT_W-1:0]  ext_l;
  logic [OUT_W-1:0]  ext_r;
  logic              capture;
  logic              drop;

  ay_mix_coef u_coef (
    .mode (mode_q),
    .step (step),
    .w_l  (w_l),
    .w_r  (w_r)
  );

  always_comb begin
    src = '0;
    if (step < LAST_STEP) begin
      src = snap[step];
    end
    if (step >= 3'd3 && !ts_q) begin
      src = '0;
    end
  end

  always_comb begin
    term_l = '0;
    term_r = '0;
    case (w_l)
      2'd1:    term_l = ACC_W'(src);
      2'd2:    term_l = ACC_W'({src, 1'b0});
      default: ;
    endcase
    case (w_r)
      2'd1:    term_r = ACC_W'(src);
      2'd2:    term_r = ACC_W'({src, 1'b0});
      default: ;
    endcase
  end

  assign ext_l   = OUT_W'(acc_l);
  assign ext_r   = OUT_W'(acc_r);
  assign capture = clken && (state == AY_ST_IDLE || (state == AY_ST_HOLD && out_ready));
  assign drop    = clken && !capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= AY_ST_IDLE;
      step      <= '0;
      mode_q    <= '0;
      ts_q      <= 1'b0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      ovr       <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        snap[i] <= '0;
      end
    end else begin
      if (drop) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end

      if (capture) begin
        snap[0]   <= ay0_a;
        snap[1]   <= ay0_b;
        snap[2]   <= ay0_c;
        snap[3]   <= ay1_a;
        snap[4]   <= ay1_b;
        snap[5]   <= ay1_c;
        mode_q    <= mode;
        ts_q      <= ts_en;
        acc_l     <= '0;
        acc_r     <= '0;
        step      <= '0;
        out_valid <= 1'b0;
        state     <= AY_ST_ACC;
      end else begin
        case (state)
          AY_ST_ACC: begin
            // six add steps, then one more cycle to register the result
            if (step < LAST_STEP) begin
              acc_l <= acc_l + term_l;
              acc_r <= acc_r + term_r;
              step  <= step + 3'd1;
            end else begin
              out_l     <= ext_l << AY_OUT_SHIFT;
              out_r     <= ext_r << AY_OUT_SHIFT;
              out_valid <= 1'b1;
              state     <= AY_ST_HOLD;
            end
          end
          AY_ST_HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= AY_ST_IDLE;
            end
          end
          default: state <= AY_ST_IDLE;
        endcase
      end
    end
  end

endmodule
